// File: rtl/struct_array_pkg.sv
// Shared types for the struct-array unpacker: element layout, word layout and FSM states.
package struct_array_pkg;

    localparam int ELEM_W  = 8;
    localparam int N_ELEMS = 4;

    typedef struct packed {
        logic       flag;
        logic [2:0] id;
        logic [3:0] val;
    } elem_t;

    typedef elem_t [N_ELEMS-1:0] struct_array_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/struct_array_unpacker_if.sv
// Word-in / element-out stream bundle; master drives words and accepts elements.
interface struct_array_unpacker_if #(
    parameter int N_ELEMS = 4,
    parameter int IDX_W   = $clog2(N_ELEMS)
);
    logic                          in_valid;
    logic                          in_ready;
    logic [N_ELEMS*8-1:0]          in_data;
    logic                          out_valid;
    logic                          out_ready;
    struct_array_pkg::elem_t       out_elem;
    logic [IDX_W-1:0]              out_idx;
    logic                          out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_elem, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_elem, out_idx, out_last
    );
endinterface

// File: rtl/struct_array_unpacker.sv
// Buffers one packed word and serialises it into one element per beat; counts retired words.
// Optional STRUCT_ARRAY_SKIP_EN: elements with flag==0 retire silently as a one-cycle bubble.
module struct_array_unpacker #(
    parameter int N_ELEMS = 4,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    struct_array_unpacker_if.slave bus,
    output logic [CNT_W-1:0]       word_cnt
);
    import struct_array_pkg::ELEM_W;
    import struct_array_pkg::elem_t;
    import struct_array_pkg::state_t;
    import struct_array_pkg::IDLE;
    import struct_array_pkg::SHIFT;

    localparam int               IDX_W    = $clog2(N_ELEMS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEMS - 1);

    state_t                      state_q, state_d;
    logic [N_ELEMS*ELEM_W-1:0]   buf_q, buf_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    elem_t                       elems [N_ELEMS];
    elem_t                       cur_elem;
    logic                        skip;
    logic                        is_last;
    logic                        retire;
    logic                        in_ready_c;
    logic                        accept;

    for (genvar gi = 0; gi < N_ELEMS; gi++) begin : g_elem
        assign elems[gi] = elem_t'(buf_q[gi*ELEM_W +: ELEM_W]);
    end

    // Retire/accept decode; in_ready looks through out_ready so words chain with no bubble.
    always_comb begin
        cur_elem = elems[idx_q];
`ifdef STRUCT_ARRAY_SKIP_EN
        skip = (state_q == SHIFT) && !cur_elem.flag;
`else
        skip = 1'b0;
`endif
        is_last    = (idx_q == LAST_IDX);
        retire     = (state_q == SHIFT) && (skip || bus.out_ready);
        in_ready_c = (state_q == IDLE) || (retire && is_last);
        accept     = bus.in_valid && in_ready_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    buf_d   = bus.in_data;
                    idx_d   = '0;
                end
            end
            SHIFT: begin
                if (retire) begin
                    if (!is_last) begin
                        idx_d = idx_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        idx_d = '0;
                        if (accept) begin
                            buf_d = bus.in_data;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = in_ready_c;
        bus.out_valid = (state_q == SHIFT) && !skip;
        bus.out_elem  = (state_q == SHIFT) ? cur_elem : '0;
        bus.out_idx   = (state_q == SHIFT) ? idx_q : '0;
        bus.out_last  = (state_q == SHIFT) && !skip && is_last;
    end

    assign word_cnt = cnt_q;

endmodule

// File: tb/tb_struct_array_unpacker.sv
// Directed + random bench for struct_array_unpacker; reference is a per-element event queue.
module tb_struct_array_unpacker;
    localparam int NE = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] word_cnt;

    struct_array_unpacker_if #(.N_ELEMS(NE)) bus ();

    struct_array_unpacker #(.N_ELEMS(NE), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] e;
        int         idx;
        bit         emit;
    } ev_t;

    ev_t           q[$];
    logic [31:0]   pend[$];
    logic [CW-1:0] exp_cnt;
    int            words_since_rst;
    int            checks;
    int            failures;
    bit            iv_gate;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected behaviour of one word: every element in order, emitted unless skipped.
    task automatic model_push(input logic [31:0] w);
        ev_t ev;
        for (int i = 0; i < NE; i++) begin
            ev.e   = w[8*i +: 8];
            ev.idx = i;
`ifdef STRUCT_ARRAY_SKIP_EN
            ev.emit = ev.e[7];
`else
            ev.emit = 1'b1;
`endif
            q.push_back(ev);
        end
    endtask

    // One clock: drive at negedge, check #1 later, update model, wait for next negedge.
    task automatic step(input bit ordy);
        bit pops, exp_ir, exp_ov, acc;
        bus.out_ready = ordy;
        bus.in_valid  = (pend.size() > 0) && iv_gate;
        bus.in_data   = (pend.size() > 0) ? pend[0] : 32'h0;
        #1;
        pops   = (q.size() > 0) && (!q[0].emit || ordy);
        exp_ov = (q.size() > 0) && q[0].emit;
        exp_ir = (q.size() == 0) || ((q[0].idx == NE-1) && pops);
        chk("in_ready", 32'(bus.in_ready), 32'(exp_ir));
        chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
        chk("word_cnt", 32'(word_cnt), 32'(exp_cnt));
        if (exp_ov) begin
            chk("out_elem", 32'(bus.out_elem), 32'(q[0].e));
            chk("out_idx", 32'(bus.out_idx), 32'(q[0].idx));
            chk("out_last", 32'(bus.out_last), 32'(q[0].idx == NE-1));
            if (ordy)
                $display("beat elem=%h idx=%0d last=%0b", bus.out_elem, bus.out_idx, bus.out_last);
        end
        if (pops) begin
            if (q[0].idx == NE-1) begin
                exp_cnt = exp_cnt + 1'b1;
                words_since_rst++;
            end
            void'(q.pop_front());
        end
        acc = bus.in_valid && bus.in_ready;
        if (acc) begin
            $display("word accepted data=%h", pend[0]);
            model_push(pend[0]);
            void'(pend.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((pend.size() > 0 || q.size() > 0) && n < 200) begin
            step(1'b1);
            n++;
        end
        chk("drain_done", 32'(pend.size() + q.size()), 32'd0);
    endtask

    task automatic apply_reset();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        pend.delete();
        exp_cnt = '0;
        words_since_rst = 0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_elem", 32'(bus.out_elem), 32'd0);
        chk("rst_out_idx", 32'(bus.out_idx), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        iv_gate = 1'b1;
        exp_cnt = '0;
        words_since_rst = 0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        apply_reset();

        // all-ones word with a ready sink
        pend.push_back(32'hFFFF_FFFF);
        drain();
        chk("t1_word_cnt", 32'(word_cnt), 32'd1);

        // stalled sink: ready pattern 1,0,0 repeating
        pend.push_back(32'h4433_2211);
        for (int i = 0; i < 15; i++) step((i % 3) == 0);
        drain();

        // two queued words, sink always ready
        pend.push_back(32'h1234_5678);
        pend.push_back(32'h9ABC_DEF0);
        drain();

        // word with cleared flags (skipped only when the skip feature is built in)
        pend.push_back(32'h008F_0081);
        drain();

        // reset in the middle of a word
        pend.push_back(32'hAABB_CCDD);
        step(1'b1);
        step(1'b1);
        step(1'b1);
        apply_reset();
        pend.push_back(32'h1122_3344);
        drain();

        // counter wrap: retire more than 2^CW words
        for (int i = 0; i < 17; i++) pend.push_back(32'hFFFF_FFFF);
        drain();
        chk("wrap_total", 32'(word_cnt), 32'(words_since_rst % (1 << CW)));

        // random words, random sink stalls and source gaps
        for (int i = 0; i < 40; i++) pend.push_back($urandom);
        for (int i = 0; i < 400 && (pend.size() > 0 || q.size() > 0); i++) begin
            iv_gate = ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 2) != 0);
        end
        iv_gate = 1'b1;
        drain();
        chk("final_cnt", 32'(word_cnt), 32'(words_since_rst % (1 << CW)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
